// File: rtl/wshb_stream_rx.sv
`default_nettype none
// ============================================================================
// Module   : wshb_stream_rx
// Purpose  : Wishbone classic-cycle write responder for the pixel stream bus.
//            Accepted 32-bit pixel writes are buffered in a first-word-fall-
//            through FIFO and re-emitted as a valid/ready stream. Each head
//            pixel is tagged with its frame position (x/y, sof, eol).
// Ports    : sys_clk, sys_rst_n          - clock, synchronous active-low reset
//            cyc, stb, we, adr, sel,
//            dat_ms                      - Wishbone master-to-slave request
//            ack, err, rty, dat_sm       - Wishbone slave response
//            out_valid, out_ready,
//            out_data                    - output pixel stream (FWFT)
//            out_sof, out_eol,
//            out_x, out_y                - frame position of the head pixel
//            level                       - FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module wshb_stream_rx #(
  parameter int HDISP      = 800,
  parameter int VDISP      = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst_n,
  input  logic                            cyc,
  input  logic                            stb,
  input  logic                            we,
  input  logic [31:0]                     adr,
  input  logic [3:0]                      sel,
  input  logic [31:0]                     dat_ms,
  output logic                            ack,
  output logic                            err,
  output logic                            rty,
  output logic [31:0]                     dat_sm,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [31:0]                     out_data,
  output logic                            out_sof,
  output logic                            out_eol,
  output logic [$clog2(HDISP)-1:0]        out_x,
  output logic [$clog2(VDISP)-1:0]        out_y,
  output logic [$clog2(FIFO_DEPTH):0]     level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_ack;
  logic          r_err;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  logic w_req;
  logic w_sel_ok;
  logic w_good;
  logic w_bad;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_valid;
  logic w_last_x;
  logic w_last_y;
  logic w_unused;

  // The address carries no information for a single-target stream port.
  assign w_unused = ^adr;

  // A request already answered (ack/err high) must not be answered twice,
  // so the registered response masks the next cycle.
  assign w_req    = cyc & stb & ~r_ack & ~r_err;
  assign w_sel_ok = (sel == 4'hF);
  assign w_good   = w_req & we & w_sel_ok;
  assign w_bad    = w_req & ~(we & w_sel_ok);
  // Full is judged on the current level only: a same-cycle pop does not
  // make room for a push (no bypass path).
  assign w_full   = (r_level == LW'(FIFO_DEPTH));
  assign w_push   = w_good & ~w_full;
  assign w_valid  = (r_level != '0);
  assign w_pop    = w_valid & out_ready;
  assign w_last_x = (r_x == XW'(HDISP - 1));
  assign w_last_y = (r_y == YW'(VDISP - 1));

  assign ack       = r_ack;
  assign err       = r_err;
  assign rty       = 1'b0;
  assign dat_sm    = 32'h0;
  assign out_valid = w_valid;
  assign out_data  = r_mem[r_rd_ptr];
  assign out_x     = r_x;
  assign out_y     = r_y;
  assign out_sof   = w_valid & (r_x == '0) & (r_y == '0);
  assign out_eol   = w_valid & w_last_x;
  assign level     = r_level;

  // Storage carries no reset: stale entries are unreachable once the
  // pointers and level are cleared.
  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= dat_ms;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_x      <= '0;
      r_y      <= '0;
    end else begin
      r_ack <= w_push;
      r_err <= w_bad;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase

      // Frame position follows the consumer, not the producer.
      if (w_pop) begin
        if (w_last_x) begin
          r_x <= '0;
          r_y <= w_last_y ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wshb_stream_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_wshb_stream_rx
// Purpose  : Self-checking bench for wshb_stream_rx. Two instances share the
//            same bus stimulus: a full-size frame (800x480) and a tiny frame
//            (4x3) so that line/frame wrap is reached quickly. Expected data
//            and positions come from a queue and a pop counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wshb_stream_rx;

  localparam int HD    = 800;
  localparam int VD    = 480;
  localparam int HB    = 4;
  localparam int VB    = 3;
  localparam int DEPTH = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc   = 1'b0;
  logic        stb   = 1'b0;
  logic        we    = 1'b0;
  logic [31:0] adr   = 32'h0;
  logic [3:0]  sel   = 4'h0;
  logic [31:0] dat   = 32'h0;
  logic        rdy   = 1'b0;

  logic        a_ack, a_err, a_rty, a_valid, a_sof, a_eol;
  logic [31:0] a_datsm, a_data;
  logic [9:0]  a_x;
  logic [8:0]  a_y;
  logic [4:0]  a_level;

  logic        b_ack, b_err, b_rty, b_valid, b_sof, b_eol;
  logic [31:0] b_datsm, b_data;
  logic [1:0]  b_x;
  logic [1:0]  b_y;
  logic [4:0]  b_level;

  logic [31:0] q[$];
  int          pops;
  int          n_checks = 0;
  int          n_pass   = 0;

  wshb_stream_rx #(.HDISP(HD), .VDISP(VD), .FIFO_DEPTH(DEPTH)) u_dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .cyc(cyc), .stb(stb), .we(we),
    .adr(adr), .sel(sel), .dat_ms(dat), .ack(a_ack), .err(a_err),
    .rty(a_rty), .dat_sm(a_datsm), .out_valid(a_valid), .out_ready(rdy),
    .out_data(a_data), .out_sof(a_sof), .out_eol(a_eol), .out_x(a_x),
    .out_y(a_y), .level(a_level)
  );

  wshb_stream_rx #(.HDISP(HB), .VDISP(VB), .FIFO_DEPTH(DEPTH)) u_dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .cyc(cyc), .stb(stb), .we(we),
    .adr(adr), .sel(sel), .dat_ms(dat), .ack(b_ack), .err(b_err),
    .rty(b_rty), .dat_sm(b_datsm), .out_valid(b_valid), .out_ready(rdy),
    .out_data(b_data), .out_sof(b_sof), .out_eol(b_eol), .out_x(b_x),
    .out_y(b_y), .level(b_level)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One Wishbone request, held until answered or a cycle budget expires.
  task automatic do_write(input logic [31:0] d, input logic [3:0] s, input logic w,
                          output logic got_a, output logic got_e);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; dat = d; adr = $urandom;
    got_a = 1'b0; got_e = 1'b0;
    for (int i = 0; i < 8 && !got_a && !got_e; i++) begin
      tick;
      got_a = a_ack;
      got_e = a_err;
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  // Check the head pixel against the model, then consume it.
  task automatic pop_one;
    int xa, ya, xb, yb;
    logic [31:0] exp_d;
    xa = pops % HD; ya = (pops / HD) % VD;
    xb = pops % HB; yb = (pops / HB) % VB;
    exp_d = (q.size() > 0) ? q[0] : 32'hX;
    n_checks++;
    if (a_valid !== 1'b1 || b_valid !== 1'b1) $display("FAIL pop_valid: got %b/%b want 1", a_valid, b_valid);
    else n_pass++;
    n_checks++;
    if (a_level !== 5'(q.size())) $display("FAIL pop_level: got %0d want %0d", a_level, q.size());
    else n_pass++;
    n_checks++;
    if (a_data !== exp_d || b_data !== exp_d) $display("FAIL pop_data: got %h/%h want %h", a_data, b_data, exp_d);
    else n_pass++;
    n_checks++;
    if (a_x !== 10'(xa) || a_y !== 9'(ya) || a_sof !== (xa == 0 && ya == 0) || a_eol !== (xa == HD - 1))
      $display("FAIL pos_a: got x=%0d y=%0d sof=%b eol=%b want x=%0d y=%0d", a_x, a_y, a_sof, a_eol, xa, ya);
    else n_pass++;
    n_checks++;
    if (b_x !== 2'(xb) || b_y !== 2'(yb) || b_sof !== (xb == 0 && yb == 0) || b_eol !== (xb == HB - 1))
      $display("FAIL pos_b: got x=%0d y=%0d sof=%b eol=%b want x=%0d y=%0d", b_x, b_y, b_sof, b_eol, xb, yb);
    else n_pass++;
    rdy = 1'b1;
    tick;
    rdy = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
    pops++;
  endtask

  task automatic drain;
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 64) begin
      if ($urandom_range(0, 3) == 0) tick;
      pop_one();
      guard++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; dat = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      tick;
      n_checks++;
      if (a_ack !== 1'b0 || a_err !== 1'b0 || a_valid !== 1'b0 || a_level !== 5'd0 || b_valid !== 1'b0)
        $display("FAIL reset: got ack=%b err=%b valid=%b level=%0d want 0", a_ack, a_err, a_valid, a_level);
      else n_pass++;
    end
    n_checks++;
    if (a_rty !== 1'b0 || a_datsm !== 32'h0) $display("FAIL tieoff: got rty=%b dat_sm=%h want 0", a_rty, a_datsm);
    else n_pass++;
    cyc = 1'b0; stb = 1'b0; rst_n = 1'b1;
    q.delete(); pops = 0;
    tick;
  endtask

  task automatic test_single;
    logic ga, ge;
    rdy = 1'b0;
    do_write(32'hCAFE_0001, 4'hF, 1'b1, ga, ge);
    n_checks++;
    if (ga !== 1'b1 || ge !== 1'b0) $display("FAIL single_resp: got ack=%b err=%b want 1/0", ga, ge);
    else n_pass++;
    q.push_back(32'hCAFE_0001);
    tick;
    n_checks++;
    if (a_ack !== 1'b0 || a_valid !== 1'b1) $display("FAIL single_pulse: got ack=%b valid=%b want 0/1", a_ack, a_valid);
    else n_pass++;
    pop_one();
  endtask

  task automatic test_full;
    logic ga, ge;
    logic [31:0] d;
    rdy = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      d = $urandom;
      do_write(d, 4'hF, 1'b1, ga, ge);
      q.push_back(d);
      n_checks++;
      if (ga !== 1'b1 || a_level !== 5'(k + 1)) $display("FAIL fill: got ack=%b level=%0d want 1/%0d", ga, a_level, k + 1);
      else n_pass++;
    end
    d = $urandom;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; dat = d;
    for (int i = 0; i < 4; i++) begin
      tick;
      n_checks++;
      if (a_ack !== 1'b0 || a_err !== 1'b0 || a_level !== 5'd16)
        $display("FAIL full_stall: got ack=%b err=%b level=%0d want 0/0/16", a_ack, a_err, a_level);
      else n_pass++;
    end
    pop_one();
    ga = 1'b0;
    for (int i = 0; i < 4 && !ga; i++) begin
      tick;
      ga = a_ack;
    end
    cyc = 1'b0; stb = 1'b0;
    q.push_back(d);
    n_checks++;
    if (ga !== 1'b1 || a_level !== 5'd16) $display("FAIL full_release: got ack=%b level=%0d want 1/16", ga, a_level);
    else n_pass++;
    drain();
  endtask

  task automatic test_errors;
    logic ga, ge;
    logic [3:0] s;
    rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      do_write(32'hA000_0000 + k, 4'hF, 1'b1, ga, ge);
      q.push_back(32'hA000_0000 + k);
    end
    do_write($urandom, 4'hF, 1'b0, ga, ge);
    n_checks++;
    if (ge !== 1'b1 || ga !== 1'b0 || a_level !== 5'd2) $display("FAIL read_err: got err=%b ack=%b level=%0d want 1/0/2", ge, ga, a_level);
    else n_pass++;
    tick;
    n_checks++;
    if (a_err !== 1'b0) $display("FAIL err_pulse: got %b want 0", a_err);
    else n_pass++;
    do_write($urandom, 4'h3, 1'b1, ga, ge);
    n_checks++;
    if (ge !== 1'b1 || ga !== 1'b0 || a_level !== 5'd2) $display("FAIL sel_err: got err=%b ack=%b level=%0d want 1/0/2", ge, ga, a_level);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      s = 4'($urandom_range(0, 14));
      do_write($urandom, s, 1'($urandom), ga, ge);
      n_checks++;
      if (ge !== 1'b1 || ga !== 1'b0 || a_level !== 5'd2) $display("FAIL rand_err: sel=%h got err=%b ack=%b level=%0d want 1/0/2", s, ge, ga, a_level);
      else n_pass++;
    end
    drain();
  endtask

  task automatic test_simultaneous;
    logic [31:0] d;
    logic ga, ge;
    rdy = 1'b0;
    do_write(32'h5555_AAAA, 4'hF, 1'b1, ga, ge);
    q.push_back(32'h5555_AAAA);
    tick;
    d = $urandom;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; dat = d; rdy = 1'b1;
    tick;
    rdy = 1'b0; cyc = 1'b0; stb = 1'b0;
    void'(q.pop_front()); pops++;
    q.push_back(d);
    n_checks++;
    if (a_ack !== 1'b1 || a_level !== 5'd1) $display("FAIL push_pop: got ack=%b level=%0d want 1/1", a_ack, a_level);
    else n_pass++;
    pop_one();
  endtask

  task automatic test_stream;
    logic ga, ge;
    logic [31:0] d;
    rdy = 1'b0;
    for (int k = 0; k < 30; k++) begin
      d = $urandom;
      do_write(d, 4'hF, 1'b1, ga, ge);
      n_checks++;
      if (ga !== 1'b1) $display("FAIL stream_ack: pixel %0d got ack=%b want 1", k, ga);
      else n_pass++;
      q.push_back(d);
      while (q.size() > 0 && $urandom_range(0, 2) != 0) pop_one();
    end
    drain();
  endtask

  task automatic test_reset_mid;
    logic ga, ge;
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      do_write($urandom, 4'hF, 1'b1, ga, ge);
      q.push_back(32'h0);
    end
    n_checks++;
    if (a_level !== 5'd5) $display("FAIL pre_reset_level: got %0d want 5", a_level);
    else n_pass++;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    q.delete(); pops = 0;
    n_checks++;
    if (a_level !== 5'd0 || a_valid !== 1'b0 || b_valid !== 1'b0) $display("FAIL mid_reset: got level=%0d valid=%b want 0/0", a_level, a_valid);
    else n_pass++;
    do_write(32'hBEEF_0013, 4'hF, 1'b1, ga, ge);
    q.push_back(32'hBEEF_0013);
    tick;
    pop_one();
  endtask

  initial begin
    pops = 0;
    test_reset();
    test_single();
    test_full();
    test_errors();
    test_simultaneous();
    test_stream();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
